// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit:
//   - 4-bit condition-code constants (CC_*)
//   - bit positions of N, Z, C, V inside a 4-bit {N,Z,C,V} flag nibble
//   - FSM state encodings (ST_RUN / ST_FLUSH) and the state width
//   - BHT counter constants (reset value and saturation limits)
// ---------------------------------------------------------------------------
package branch_pkg;

    // Condition codes. Codes E and F are reserved and never take.
    localparam logic [3:0] CC_NEVER  = 4'h0;
    localparam logic [3:0] CC_ALWAYS = 4'h1;
    localparam logic [3:0] CC_EQ     = 4'h2;
    localparam logic [3:0] CC_NE     = 4'h3;
    localparam logic [3:0] CC_CS     = 4'h4;
    localparam logic [3:0] CC_CC     = 4'h5;
    localparam logic [3:0] CC_MI     = 4'h6;
    localparam logic [3:0] CC_PL     = 4'h7;
    localparam logic [3:0] CC_VS     = 4'h8;
    localparam logic [3:0] CC_VC     = 4'h9;
    localparam logic [3:0] CC_GE     = 4'hA;
    localparam logic [3:0] CC_LT     = 4'hB;
    localparam logic [3:0] CC_GT     = 4'hC;
    localparam logic [3:0] CC_LE     = 4'hD;
    localparam logic [3:0] CC_RSV_E  = 4'hE;
    localparam logic [3:0] CC_RSV_F  = 4'hF;

    // Bit positions inside a {N,Z,C,V} nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FSM state encodings.
    localparam int         STATE_W  = 1;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // 2-bit BHT counter values.
    localparam logic [1:0] BHT_RESET = 2'b01;
    localparam logic [1:0] BHT_MAX   = 2'b11;
    localparam logic [1:0] BHT_MIN   = 2'b00;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
// Branch resolution bus between the pipeline (master) and the resolve unit
// (slave).
//   iBranchValid      m->s  branch presented this cycle
//   iBranchOperation  m->s  4-bit condition code
//   iAccSel           m->s  accumulator flag set selected
//   iBranchPC         m->s  PC of the resolving branch
//   iPredicted        m->s  prediction made at fetch
//   oResolveValid     s->m  registered result valid (one cycle per accept)
//   oBranchTaken      s->m  registered actual outcome
//   oMispredict       s->m  registered outcome != iPredicted
//
// Handshake: there is no ready signal. A branch is accepted on the rising
// edge where iBranchValid=1 and the unit is in RUN; during a flush the
// presented branch is dropped silently. Each accepted branch produces
// exactly one oResolveValid pulse in the following cycle.
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
    parameter int NUM_ACC  = 2,
    parameter int PC_WIDTH = 10
);
    localparam int SEL_W = $clog2(NUM_ACC);

    logic                iBranchValid;
    logic [3:0]          iBranchOperation;
    logic [SEL_W-1:0]    iAccSel;
    logic [PC_WIDTH-1:0] iBranchPC;
    logic                iPredicted;
    logic                oResolveValid;
    logic                oBranchTaken;
    logic                oMispredict;

    modport master (
        output iBranchValid, iBranchOperation, iAccSel, iBranchPC, iPredicted,
        input  oResolveValid, oBranchTaken, oMispredict
    );

    modport slave (
        input  iBranchValid, iBranchOperation, iAccSel, iBranchPC, iPredicted,
        output oResolveValid, oBranchTaken, oMispredict
    );

endinterface

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational condition evaluator.
//   op     in  4  condition code (CC_* in branch_pkg)
//   flags  in  4  {N,Z,C,V}
//   taken  out 1  condition true
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (op)
            CC_NEVER:  taken = 1'b0;
            CC_ALWAYS: taken = 1'b1;
            CC_EQ:     taken = z;
            CC_NE:     taken = ~z;
            CC_CS:     taken = c;
            CC_CC:     taken = ~c;
            CC_MI:     taken = n;
            CC_PL:     taken = ~n;
            CC_VS:     taken = v;
            CC_VC:     taken = ~v;
            CC_GE:     taken = (n == v);
            CC_LT:     taken = (n != v);
            CC_GT:     taken = ~z & (n == v);
            CC_LE:     taken = z | (n != v);
            default:   taken = 1'b0;   // reserved E/F never take
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves conditional branches against per-accumulator NZCV flags, trains a
// 2-bit-counter branch history table, requests a pipeline flush on a
// mispredict and keeps saturating branch/mispredict statistics.
//
// Ports:
//   Clock             in   rising-edge clock
//   Reset_n           in   asynchronous active-low reset
//   iFlagWe           in   per-accumulator flag write enable
//   iFlags            in   {N,Z,C,V} per accumulator, acc i at [4i+3:4i]
//   iFetchPC          in   PC looked up for prediction
//   oPredictTaken     out  combinational prediction (counter MSB)
//   bus               slave side of the branch resolution bus
//   oFlush            out  pipeline flush request, FLUSH_CYCLES long
//   oBranchCount      out  accepted branches (saturating)
//   oMispredictCount  out  accepted mispredicts (saturating)
//   oState            out  FSM state (ST_RUN / ST_FLUSH) for observation
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int NUM_ACC      = 2,
    parameter int PC_WIDTH     = 10,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic [NUM_ACC-1:0]     iFlagWe,
    input  logic [4*NUM_ACC-1:0]   iFlags,
    input  logic [PC_WIDTH-1:0]    iFetchPC,
    output logic                   oPredictTaken,
    branch_resolve_unit_if.slave   bus,
    output logic                   oFlush,
    output logic [CNT_WIDTH-1:0]   oBranchCount,
    output logic [CNT_WIDTH-1:0]   oMispredictCount,
    output logic [STATE_W-1:0]     oState
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Flag registers
    // -----------------------------------------------------------------------
    logic [3:0] flags_q  [NUM_ACC];
    logic [3:0] flags_in [NUM_ACC];

    for (genvar g = 0; g < NUM_ACC; g++) begin : g_flag_slice
        assign flags_in[g] = iFlags[4*g +: 4];
    end

    // Flags keep loading in every FSM state, including FLUSH.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_ACC; i++) flags_q[i] <= 4'h0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (iFlagWe[i]) flags_q[i] <= flags_in[i];
            end
        end
    end

    // A flag write to the selected accumulator in the resolve cycle is
    // forwarded so a branch right behind a flag-setting op sees new flags.
    logic [3:0] sel_flags;

    always_comb begin
        sel_flags = flags_q[bus.iAccSel];
        if (iFlagWe[bus.iAccSel]) sel_flags = flags_in[bus.iAccSel];
    end

    logic cond_taken;

    branch_cond_eval u_cond_eval (
        .op    (bus.iBranchOperation),
        .flags (sel_flags),
        .taken (cond_taken)
    );

    // -----------------------------------------------------------------------
    // FSM: RUN accepts branches, FLUSH drops them while oFlush is high
    // -----------------------------------------------------------------------
    logic [STATE_W-1:0] state_q;
    logic [FC_W-1:0]    flush_cnt_q;
    logic               accept;
    logic               mispredict;

    assign accept     = bus.iBranchValid && (state_q == ST_RUN);
    assign mispredict = accept && (cond_taken != bus.iPredicted);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mispredict) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_LAST;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) state_q <= ST_RUN;
                    else                   flush_cnt_q <= flush_cnt_q - 1'b1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // FLUSH is entered on the same edge that registers the mispredict, so
    // deriving oFlush from the state lines it up with oMispredict.
    assign oFlush = (state_q == ST_FLUSH);
    assign oState = state_q;

    // -----------------------------------------------------------------------
    // Registered resolution results
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.oResolveValid <= 1'b0;
            bus.oBranchTaken  <= 1'b0;
            bus.oMispredict   <= 1'b0;
        end else begin
            bus.oResolveValid <= accept;
            bus.oBranchTaken  <= accept && cond_taken;
            bus.oMispredict   <= mispredict;
        end
    end

    // -----------------------------------------------------------------------
    // Branch history table
    // -----------------------------------------------------------------------
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] fetch_idx;

    assign upd_idx   = bus.iBranchPC[IDX_W-1:0];
    assign fetch_idx = iFetchPC[IDX_W-1:0];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_RESET;
        end else if (accept) begin
            if (cond_taken) begin
                if (bht_q[upd_idx] != BHT_MAX) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            end else begin
                if (bht_q[upd_idx] != BHT_MIN) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
            end
        end
    end

    // Read straight from the registers, so a same-cycle update at the same
    // index is not visible until the next cycle.
    assign oPredictTaken = bht_q[fetch_idx][1];

    // -----------------------------------------------------------------------
    // Saturating statistics
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            oBranchCount     <= '0;
            oMispredictCount <= '0;
        end else begin
            if (accept && (oBranchCount != '1))
                oBranchCount <= oBranchCount + 1'b1;
            if (mispredict && (oMispredictCount != '1))
                oMispredictCount <= oMispredictCount + 1'b1;
        end
    end

    // Only the low PC bits index the BHT.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{iFetchPC[PC_WIDTH-1:IDX_W], bus.iBranchPC[PC_WIDTH-1:IDX_W]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int NUM_ACC = 2;
    localparam int PC_W    = 10;
    localparam int DEPTH   = 16;
    localparam int FLUSH_N = 2;
    localparam int CNT_MAX = 65535;

    // ---------------- clock / reset ----------------
    logic Clock;
    logic Reset_n;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- DUT 1 (defaults) ----------------
    logic [NUM_ACC-1:0]   flag_we;
    logic [4*NUM_ACC-1:0] flags;
    logic [PC_W-1:0]      fetch_pc;
    logic                 predict_taken;
    logic                 flush;
    logic [15:0]          branch_count;
    logic [15:0]          mis_count;
    logic [0:0]           state;

    branch_resolve_unit_if #(.NUM_ACC(NUM_ACC), .PC_WIDTH(PC_W)) bus ();

    branch_resolve_unit #(
        .NUM_ACC(NUM_ACC), .PC_WIDTH(PC_W), .BHT_DEPTH(DEPTH),
        .FLUSH_CYCLES(FLUSH_N), .CNT_WIDTH(16)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .iFlagWe(flag_we), .iFlags(flags), .iFetchPC(fetch_pc),
        .oPredictTaken(predict_taken), .bus(bus), .oFlush(flush),
        .oBranchCount(branch_count), .oMispredictCount(mis_count), .oState(state)
    );

    // ---------------- DUT 2 (4-bit counters) ----------------
    logic [NUM_ACC-1:0]   flag_we2;
    logic [4*NUM_ACC-1:0] flags2;
    logic [PC_W-1:0]      fetch_pc2;
    logic                 predict_taken2;
    logic                 flush2;
    logic [3:0]           branch_count2;
    logic [3:0]           mis_count2;
    logic [0:0]           state2;

    branch_resolve_unit_if #(.NUM_ACC(NUM_ACC), .PC_WIDTH(PC_W)) bus2 ();

    branch_resolve_unit #(
        .NUM_ACC(NUM_ACC), .PC_WIDTH(PC_W), .BHT_DEPTH(DEPTH),
        .FLUSH_CYCLES(FLUSH_N), .CNT_WIDTH(4)
    ) dut2 (
        .Clock(Clock), .Reset_n(Reset_n),
        .iFlagWe(flag_we2), .iFlags(flags2), .iFetchPC(fetch_pc2),
        .oPredictTaken(predict_taken2), .bus(bus2), .oFlush(flush2),
        .oBranchCount(branch_count2), .oMispredictCount(mis_count2), .oState(state2)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    // ---------------- reference model (DUT 1) ----------------
    logic [3:0] flags_m [NUM_ACC];
    int         bht_m   [DEPTH];
    int         bc_m;
    int         mc_m;
    int         flush_left;
    logic [2:0] exp_q [$];   // {valid, taken, mispredict}

    function automatic bit ref_cond(input logic [3:0] op, input logic [3:0] f);
        bit n, z, c, v;
        bit t [16];
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        t = '{1'b0, 1'b1, z, !z, c, !c, n, !n, v, !v,
              (n == v), (n != v), (!z && (n == v)), (z || (n != v)), 1'b0, 1'b0};
        return t[op];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ACC; i++) flags_m[i] = 4'h0;
        for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
        bc_m = 0;
        mc_m = 0;
        flush_left = 0;
        exp_q.delete();
    endtask

    // One clock: predict DUT 1 from current inputs, advance, sample at +1.
    task automatic tick();
        logic [3:0] f;
        bit tk, acc, mis;
        int idx;
        f   = flag_we[bus.iAccSel] ? flags[4*bus.iAccSel +: 4] : flags_m[bus.iAccSel];
        tk  = ref_cond(bus.iBranchOperation, f);
        acc = bus.iBranchValid && (flush_left == 0);
        mis = acc && (tk != bus.iPredicted);
        if (flush_left > 0) flush_left--;
        if (mis) flush_left = FLUSH_N;
        for (int i = 0; i < NUM_ACC; i++) if (flag_we[i]) flags_m[i] = flags[4*i +: 4];
        if (acc) begin
            idx = bus.iBranchPC % DEPTH;
            if (tk) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
            else    bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
            if (bc_m < CNT_MAX) bc_m++;
            if (mis && mc_m < CNT_MAX) mc_m++;
        end
        exp_q.push_back({acc, acc && tk, mis});
        @(posedge Clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        flag_we = '0; flags = '0; fetch_pc = '0;
        bus.iBranchValid = 1'b0; bus.iBranchOperation = 4'h0; bus.iAccSel = '0;
        bus.iBranchPC = '0; bus.iPredicted = 1'b0;
        flag_we2 = '0; flags2 = '0; fetch_pc2 = '0;
        bus2.iBranchValid = 1'b0; bus2.iBranchOperation = 4'h0; bus2.iAccSel = '0;
        bus2.iBranchPC = '0; bus2.iPredicted = 1'b0;
    endtask

    task automatic set_branch(input bit valid, input logic [3:0] op, input bit sel,
                              input int pc, input bit pred);
        bus.iBranchValid = valid; bus.iBranchOperation = op; bus.iAccSel = sel;
        bus.iBranchPC = pc[PC_W-1:0]; bus.iPredicted = pred;
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        Reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // values while reset is held from time zero
        #1;
        tests++;
        if ({bus.oResolveValid, bus.oBranchTaken, bus.oMispredict, flush, state} !== 5'b0 ||
            branch_count !== 16'd0 || mis_count !== 16'd0 || predict_taken !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: rv=%b tk=%b mp=%b fl=%b st=%b bc=%0d mc=%0d pr=%b, required all 0",
                     bus.oResolveValid, bus.oBranchTaken, bus.oMispredict, flush, state,
                     branch_count, mis_count, predict_taken);
        end
        apply_reset();
        // train PC 3 twice, then reset asynchronously mid-cycle
        set_branch(1, 4'h1, 0, 3, 1);
        tick(); tick();
        set_branch(0, 4'h0, 0, 0, 0);
        fetch_pc = 10'd3;
        #2;
        Reset_n = 1'b0;
        #1;
        tests++;
        if (branch_count !== 16'd0 || predict_taken !== 1'b0 || bus.oResolveValid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: bc=%0d pred=%b rv=%b, required 0 0 0",
                     branch_count, predict_taken, bus.oResolveValid);
        end
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_always_mispredict();
        apply_reset();
        fetch_pc = 10'd5;
        set_branch(1, 4'h1, 0, 5, 0);
        #1;
        tests++;
        if (predict_taken !== 1'b0) begin
            fails++; $display("FAIL fetch_pc5_pred: got %b required 0", predict_taken);
        end
        tick();
        set_branch(0, 4'h0, 0, 0, 0);
        tests++;
        if (bus.oResolveValid !== 1'b1 || bus.oBranchTaken !== 1'b1 || bus.oMispredict !== 1'b1 ||
            flush !== 1'b1 || mis_count !== 16'd1 || branch_count !== 16'd1) begin
            fails++;
            $display("FAIL always_mispredict: rv=%b tk=%b mp=%b fl=%b mc=%0d bc=%0d, required 1 1 1 1 1 1",
                     bus.oResolveValid, bus.oBranchTaken, bus.oMispredict, flush, mis_count, branch_count);
        end
        tick();
        tests++;
        if (flush !== 1'b1 || bus.oResolveValid !== 1'b0 || bus.oMispredict !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle2: fl=%b rv=%b mp=%b, required 1 0 0", flush, bus.oResolveValid, bus.oMispredict);
        end
        tick();
        tests++;
        if (flush !== 1'b0 || state !== 1'b0) begin
            fails++; $display("FAIL flush_end: fl=%b st=%b, required 0 0", flush, state);
        end
    endtask

    task automatic test_lt_bypass();
        apply_reset();
        flag_we = 2'b10; flags = {4'b1000, 4'b0000};
        tick();
        flag_we = 2'b00; flags = '0;
        set_branch(1, 4'hB, 1, 8, 1);
        tick();
        set_branch(0, 4'h0, 0, 0, 0);
        tests++;
        if (bus.oResolveValid !== 1'b1 || bus.oBranchTaken !== 1'b1 || bus.oMispredict !== 1'b0) begin
            fails++;
            $display("FAIL lt_stored: rv=%b tk=%b mp=%b, required 1 1 0", bus.oResolveValid, bus.oBranchTaken, bus.oMispredict);
        end
        apply_reset();
        flag_we = 2'b10; flags = {4'b1000, 4'b0000};
        set_branch(1, 4'hB, 1, 8, 1);
        tick();
        flag_we = 2'b00; flags = '0;
        set_branch(0, 4'h0, 0, 0, 0);
        tests++;
        if (bus.oResolveValid !== 1'b1 || bus.oBranchTaken !== 1'b1 || bus.oMispredict !== 1'b0) begin
            fails++;
            $display("FAIL lt_bypass: rv=%b tk=%b mp=%b, required 1 1 0", bus.oResolveValid, bus.oBranchTaken, bus.oMispredict);
        end
    endtask

    task automatic test_bht_saturate();
        apply_reset();
        set_branch(1, 4'h1, 0, 3, 1);
        for (int i = 0; i < 4; i++) tick();
        set_branch(0, 4'h0, 0, 0, 0);
        fetch_pc = 10'd3;
        #1;
        tests++;
        if (predict_taken !== 1'b1) begin
            fails++; $display("FAIL bht_pc3_taken: got %b required 1", predict_taken);
        end
        fetch_pc = 10'd19;
        #1;
        tests++;
        if (predict_taken !== 1'b1) begin
            fails++; $display("FAIL bht_pc19_alias: got %b required 1", predict_taken);
        end
        fetch_pc = 10'd3;
        set_branch(1, 4'h0, 0, 3, 0);
        tick();
        tests++;
        if (predict_taken !== 1'b1 || bus.oBranchTaken !== 1'b0) begin
            fails++;
            $display("FAIL bht_after_one_nt: pred=%b tk=%b, required 1 0", predict_taken, bus.oBranchTaken);
        end
        tick();
        set_branch(0, 4'h0, 0, 0, 0);
        tests++;
        if (predict_taken !== 1'b0) begin
            fails++; $display("FAIL bht_after_two_nt: got %b required 0", predict_taken);
        end
    endtask

    task automatic test_flush_ignore();
        apply_reset();
        fetch_pc = 10'd5;
        set_branch(1, 4'h1, 0, 5, 0);
        tick();
        set_branch(1, 4'h0, 0, 5, 0);
        tick();
        tests++;
        if (bus.oResolveValid !== 1'b0 || branch_count !== 16'd1 || flush !== 1'b1) begin
            fails++;
            $display("FAIL flush_drop1: rv=%b bc=%0d fl=%b, required 0 1 1", bus.oResolveValid, branch_count, flush);
        end
        tick();
        set_branch(0, 4'h0, 0, 0, 0);
        tests++;
        if (bus.oResolveValid !== 1'b0 || branch_count !== 16'd1 || predict_taken !== 1'b1) begin
            fails++;
            $display("FAIL flush_drop2: rv=%b bc=%0d pred=%b, required 0 1 1", bus.oResolveValid, branch_count, predict_taken);
        end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        set_branch(1, 4'h1, 0, 5, 0);
        tick();
        set_branch(0, 4'h0, 0, 0, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        tests++;
        if (flush !== 1'b0 || state !== 1'b0 || bus.oMispredict !== 1'b0 || mis_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_flush: fl=%b st=%b mp=%b mc=%0d, required 0 0 0 0", flush, state, bus.oMispredict, mis_count);
        end
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
        set_branch(1, 4'h1, 0, 7, 1);
        tick();
        set_branch(0, 4'h0, 0, 0, 0);
        tests++;
        if (bus.oResolveValid !== 1'b1 || bus.oBranchTaken !== 1'b1 || branch_count !== 16'd1) begin
            fails++;
            $display("FAIL first_edge_accept: rv=%b tk=%b bc=%0d, required 1 1 1", bus.oResolveValid, bus.oBranchTaken, branch_count);
        end
    endtask

    task automatic test_count_saturate();
        apply_reset();
        bus2.iBranchValid = 1'b1; bus2.iBranchOperation = 4'h1; bus2.iPredicted = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (branch_count2 !== 4'd15 || mis_count2 !== 4'd0) begin
            fails++;
            $display("FAIL cnt4_saturate: bc=%0d mc=%0d, required 15 0", branch_count2, mis_count2);
        end
        for (int op = 14; op < 16; op++) begin
            bus2.iBranchOperation = 4'(op); bus2.iPredicted = 1'b0;
            flag_we2 = 2'b01; flags2 = 8'h0F;
            set_branch(1, 4'(op), 0, 2, 0);
            tick();
            tests++;
            if (bus2.oBranchTaken !== 1'b0 || bus2.oResolveValid !== 1'b1 ||
                bus.oBranchTaken !== 1'b0 || bus.oMispredict !== 1'b0) begin
                fails++;
                $display("FAIL reserved_op_%0h: tk2=%b rv2=%b tk=%b mp=%b, required 0 1 0 0",
                         op, bus2.oBranchTaken, bus2.oResolveValid, bus.oBranchTaken, bus.oMispredict);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [2:0] exp;
        int errs;
        apply_reset();
        errs = 0;
        for (int n = 0; n < 600; n++) begin
            flag_we  = 2'($urandom_range(0, 3));
            flags    = 8'($urandom);
            fetch_pc = 10'($urandom);
            set_branch($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
            #1;
            tests++;
            if (predict_taken !== (bht_m[fetch_pc % DEPTH] >= 2)) begin
                fails++; errs++;
                if (errs < 10) $display("FAIL rand_pred[%0d]: got %b required %b", n, predict_taken, bht_m[fetch_pc % DEPTH] >= 2);
            end
            tick();
            exp = exp_q.pop_front();
            tests++;
            if ({bus.oResolveValid, bus.oBranchTaken, bus.oMispredict} !== exp ||
                flush !== (flush_left > 0) || branch_count !== 16'(bc_m) || mis_count !== 16'(mc_m)) begin
                fails++; errs++;
                if (errs < 10)
                    $display("FAIL rand_result[%0d]: rv/tk/mp=%b fl=%b bc=%0d mc=%0d, required %b %b %0d %0d",
                             n, {bus.oResolveValid, bus.oBranchTaken, bus.oMispredict}, flush,
                             branch_count, mis_count, exp, flush_left > 0, bc_m, mc_m);
            end
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Reset_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_always_mispredict();
        test_lt_bypass();
        test_bht_saturate();
        test_flush_ignore();
        test_reset_mid_flush();
        test_count_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
